// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX core among NUM_REQ byte producers.
// Latency: byte accepted (req_ready) in cycle N, tx_valid pulse in N+1; next grant 1 cycle after tx_busy falls.
// Backpressure: no grant while busy with a frame or while tx_busy is high; optional bursts via UART_ARB_BURST_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int WIDTH        = 8,
   parameter int BUSY_TIMEOUT = 4,
   localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CW          = $clog2(BUSY_TIMEOUT + 1)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]       req_last,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     tx_busy,
   output logic                     tx_valid,
   output logic [WIDTH-1:0]         tx_data,
   output logic [IDW-1:0]           grant_id,
   output logic                     arb_busy,
   output logic                     tx_err
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ISSUE     = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   logic [1:0]         state;
   logic [IDW-1:0]     rr_ptr;
   logic [CW-1:0]      cnt;
   logic [NUM_REQ-1:0] cand;
   logic               win_found;
   logic [IDW-1:0]     win_idx;
   logic               accept;

`ifdef UART_ARB_BURST_EN
   logic               lock;
   logic [IDW-1:0]     lock_id;

   // While a burst is open only its owner is eligible.
   always_comb begin
      cand = req_valid;
      if (lock) begin
         cand = '0;
         cand[lock_id] = req_valid[lock_id];
      end
   end

   // Open a lock on a non-final byte, release it on the final one.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         lock    <= 1'b0;
         lock_id <= '0;
      end else if (accept) begin
         lock    <= ~req_last[win_idx];
         lock_id <= win_idx;
      end
   end
`else
   logic unused_last;
   assign unused_last = ^req_last;

   // Every valid requester competes for every byte.
   always_comb begin
      cand = req_valid;
   end
`endif

   // Round-robin search starting just after the last owner, wrapping modulo NUM_REQ.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_idx   = IDW'(idx);
         end
      end
   end

   // Grant only from IDLE with the TX core quiet; reset also masks the combinational accept.
   assign accept    = (state == S_IDLE) && !tx_busy && win_found && RST;
   assign req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;
   assign tx_valid  = (state == S_ISSUE);
   assign arb_busy  = (state != S_IDLE);

   // Frame sequencer: capture, pulse, wait for busy to rise (with timeout), wait for busy to fall.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= S_IDLE;
         rr_ptr   <= IDW'(NUM_REQ - 1);
         cnt      <= '0;
         tx_data  <= '0;
         grant_id <= '0;
         tx_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  tx_data  <= req_data[int'(win_idx)*WIDTH +: WIDTH];
                  grant_id <= win_idx;
`ifdef UART_ARB_BURST_EN
                  if (req_last[win_idx]) rr_ptr <= win_idx;
`else
                  rr_ptr   <= win_idx;
`endif
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt   <= '0;
               state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               // BUSY_TIMEOUT cycles are allowed here for the core to react.
               if (tx_busy) begin
                  state <= S_WAIT_DONE;
               end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                  tx_err <= 1'b1;
                  state  <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if (!tx_busy) state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a timeline-level reference model and a TX core model.
module tb_uart_tx_arbiter;
   localparam int NR = 4;
   localparam int W  = 8;
   localparam int BT = 4;

   logic            CLK = 1'b0;
   logic            RST;
   logic [NR-1:0]   req_valid;
   logic [NR*W-1:0] req_data;
   logic [NR-1:0]   req_last;
   logic [NR-1:0]   req_ready;
   logic            tx_busy;
   logic            tx_valid;
   logic [W-1:0]    tx_data;
   logic [1:0]      grant_id;
   logic            arb_busy;
   logic            tx_err;

   uart_tx_arbiter #(.NUM_REQ(NR), .WIDTH(W), .BUSY_TIMEOUT(BT)) dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_busy(tx_busy),
      .tx_valid(tx_valid), .tx_data(tx_data), .grant_id(grant_id),
      .arb_busy(arb_busy), .tx_err(tx_err)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // reference model: arbiter as a timeline of "busy until" cycles
   int         m_rr, m_grant, m_free, m_issue, m_err_at, m_owner;
   logic [W-1:0] m_data;
   bit         m_lock;
   // TX core model
   int bs = -10, be = -10, frame_len = 1;
   bit frame_dead = 1'b0, tx_dead = 1'b0, ext_busy = 1'b0;
   // stimulus
   int mode = 0;
   bit rst_next = 1'b0;
   logic [NR-1:0]   nv = '0;
   logic [NR*W-1:0] nd = '0;
   logic [NR-1:0]   nl = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_rr = NR - 1; m_grant = 0; m_free = 0; m_issue = -1;
      m_err_at = -1; m_data = '0; m_lock = 1'b0; m_owner = 0;
   endtask

   function automatic int pick(input logic [NR-1:0] v, input int rr);
      for (int k = 1; k <= NR; k++) begin
         if (v[(rr + k) % NR]) return (rr + k) % NR;
      end
      return -1;
   endfunction

   task automatic check_cycle();
      logic [NR-1:0] cand;
      logic [NR-1:0] er;
      int g;
      if (!RST) begin
         model_reset();
         chk("rst_req_ready", 32'(req_ready), 0);
         chk("rst_tx_valid", 32'(tx_valid), 0);
         chk("rst_tx_data", 32'(tx_data), 0);
         chk("rst_grant_id", 32'(grant_id), 0);
         chk("rst_arb_busy", 32'(arb_busy), 0);
         chk("rst_tx_err", 32'(tx_err), 0);
         return;
      end
      chk("arb_busy", 32'(arb_busy), 32'(cyc < m_free));
      chk("tx_valid", 32'(tx_valid), 32'(cyc == m_issue));
      chk("tx_data", 32'(tx_data), 32'(m_data));
      chk("grant_id", 32'(grant_id), 32'(m_grant));
      chk("tx_err", 32'(tx_err), 32'(m_err_at >= 0 && cyc >= m_err_at));
      chk("valid_while_busy", 32'(tx_valid & tx_busy), 0);
      // TX core reacts to the pulse it sees
      if (tx_valid && !frame_dead) begin
         bs = cyc + 1;
         be = cyc + frame_len;
      end
      er = '0;
      g  = -1;
      if (cyc >= m_free && !tx_busy) begin
         cand = req_valid;
`ifdef UART_ARB_BURST_EN
         if (m_lock) begin
            cand = '0;
            cand[m_owner] = req_valid[m_owner];
         end
`endif
         g = pick(cand, m_rr);
         if (g >= 0) er[g] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(er));
      if (g >= 0) begin
         m_grant = g;
         m_data  = req_data[g*W +: W];
         m_issue = cyc + 1;
`ifdef UART_ARB_BURST_EN
         if (req_last[g]) begin m_lock = 1'b0; m_rr = g; end
         else begin m_lock = 1'b1; m_owner = g; end
`else
         m_rr = g;
`endif
         frame_dead = tx_dead;
         frame_len  = $urandom_range(1, 12);
         if (frame_dead) begin
            m_free = cyc + 2 + BT;
            if (m_err_at < 0) m_err_at = m_free;
         end else begin
            m_free = cyc + 3 + frame_len;
         end
      end
   endtask

   task automatic step();
      @(posedge CLK);
      cyc++;
      #1;
      RST = rst_next;
      case (mode)
         0: if ($urandom_range(0, 2) == 0) nv = NR'($urandom_range(0, 15));
         1: nv = '1;
         3: begin
            if ($urandom_range(0, 2) == 0) nv = NR'($urandom_range(0, 15));
            ext_busy = (cyc >= m_free) ? ($urandom_range(0, 2) != 0) : 1'b0;
         end
         4: nv = 4'b0100;
         default: nv = 4'b0001;
      endcase
      if (mode != 3) ext_busy = 1'b0;
      for (int i = 0; i < NR; i++) nd[i*W +: W] = W'($urandom_range(0, 255));
      if (mode == 5) nd[W-1:0] = 8'hA5;
      nl = NR'($urandom_range(0, 15));
      tx_busy   = ((cyc >= bs) && (cyc <= be)) || ext_busy;
      req_valid = nv;
      req_data  = nd;
      req_last  = nl;
      @(negedge CLK);
      check_cycle();
   endtask

   initial begin
      bit found;
      RST = 1'b0; tx_busy = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
      model_reset();
      // reset with requests pending: nothing may be granted
      mode = 0;
      repeat (3) step();
      rst_next = 1'b1;
      // single requester, fixed byte
      mode = 5;
      repeat (40) step();
      // everybody requesting: rotation 0,1,2,3,0...
      mode = 1;
      repeat (150) step();
      // TX core that never answers, then a healthy one again
      tx_dead = 1'b1; mode = 0;
      repeat (60) step();
      tx_dead = 1'b0;
      repeat (60) step();
      // core driven externally while arbiter idle
      mode = 3;
      repeat (200) step();
      // reset while waiting for the frame to finish, then requester 2 alone
      mode = 1; found = 1'b0;
      for (int t = 0; t < 100 && !found; t++) begin
         step();
         if (!frame_dead && bs > 0 && cyc >= bs && cyc < be && cyc < m_free) found = 1'b1;
      end
      chk("reach_wait_done", 32'(found), 1);
      rst_next = 1'b0;
      repeat (2) step();
      rst_next = 1'b1;
      mode = 4;
      repeat (40) step();
      // long random soak with occasional dead frames and resets
      for (int t = 0; t < 3000; t++) begin
         if (t % 100 == 0) mode = ($urandom_range(0, 2) == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 0 : 3);
         if ($urandom_range(0, 59) == 0) tx_dead = !tx_dead;
         rst_next = ($urandom_range(0, 399) != 0);
         step();
      end
      tx_dead = 1'b0; rst_next = 1'b1; mode = 0;
      repeat (40) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
